// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;

  function automatic int starve_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

  localparam int STARVE_W = starve_width(STARVE_MAX_DEF);

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// Zero latency on o_sat (registered count); no backpressure, clear has priority over increment.
module arb_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port sync memory between fetch and load/store; grant is combinational, response 1 cycle later.
// Losing requester sees STALL and holds its request; fetch is forced through after STARVE_MAX data wins.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_VALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_RD_EN,
  input  logic              D_WR_EN,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_VALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              STALL,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_RD_EN,
  output logic              MEM_WR_EN,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  logic   w_d_req;
  logic   w_sat;
  owner_e w_owner_nxt;
  owner_e r_owner;
  logic   r_owner_wr;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  assign w_d_req = D_RD_EN | D_WR_EN;

  // Data wins contention until the starve counter saturates, then fetch gets one slot.
  assign IF_GNT = IF_REQ & (~w_d_req | w_sat);
  assign D_GNT  = w_d_req & (~IF_REQ | ~w_sat);
  assign STALL  = (IF_REQ & ~IF_GNT) | (w_d_req & ~D_GNT);

  arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (starve_width(STARVE_MAX))
  ) u_starve (
    .CLK   (CLK),
    .RST   (RST),
    .i_inc (D_GNT & IF_REQ),
    .i_clr (IF_GNT | ~IF_REQ),
    .o_sat (w_sat)
  );

  always_comb begin
    MEM_ADDR    = '0;
    MEM_WDATA   = '0;
    MEM_RD_EN   = 1'b0;
    MEM_WR_EN   = 1'b0;
    w_owner_nxt = OWN_NONE;
    if (IF_GNT) begin
      MEM_ADDR    = IF_ADDR;
      MEM_RD_EN   = 1'b1;
      w_owner_nxt = OWN_IF;
    end else if (D_GNT) begin
      MEM_ADDR    = D_ADDR;
      MEM_WDATA   = D_WDATA;
      MEM_WR_EN   = D_WR_EN;
      MEM_RD_EN   = D_RD_EN & ~D_WR_EN;
      w_owner_nxt = OWN_D;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner    <= OWN_NONE;
      r_owner_wr <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_owner_wr <= D_GNT & D_WR_EN;
    end
  end

  // Read data passes straight through in the response cycle and is held afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_owner == OWN_IF) r_if_rdata <= MEM_RDATA;
      if ((r_owner == OWN_D) && !r_owner_wr) r_d_rdata <= MEM_RDATA;
    end
  end

  assign IF_VALID = (r_owner == OWN_IF);
  assign D_VALID  = (r_owner == OWN_D);
  assign IF_RDATA = IF_VALID ? MEM_RDATA : r_if_rdata;
  assign D_RDATA  = (D_VALID && !r_owner_wr) ? MEM_RDATA : r_d_rdata;

endmodule
